// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt arbiter: register map and FSM state encoding.
package intc_pkg;

    localparam logic [1:0] INTC_MASK   = 2'd0;
    localparam logic [1:0] INTC_PEND   = 2'd1;
    localparam logic [1:0] INTC_ACTIVE = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } intc_state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational priority encoder: the first set bit of `in` at or after `start` wins,
// wrapping modulo NUM_SRC.
module intc_prio_enc #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_SRC-1:0] in,
    input  logic [ID_W-1:0]    start,
    output logic [ID_W-1:0]    out_id,
    output logic               any
);

    logic [NUM_SRC-1:0] rot;
    logic [NUM_SRC-1:0] probe;
    int unsigned        pos;

    always_comb begin
        out_id = '0;
        any    = 1'b0;
        probe  = '0;
        pos    = 0;
        // Rotate so that bit 0 of rot corresponds to source `start`.
        rot = (in >> start) | (in << (NUM_SRC - 32'(start)));
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            probe = rot >> i;
            if (!any && probe[0]) begin
                any = 1'b1;
                pos = 32'(start) + i;
                if (pos >= NUM_SRC) begin
                    pos = pos - NUM_SRC;
                end
                out_id = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: edge-latched pending, mask, single-winner assert/taken/service/eret sequencing.
// Define ROUND_ROBIN_EN for rotating priority; otherwise fixed priority (lowest index wins).
module interrupt_arbiter
    import intc_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] req,
    input  logic               wr_en,
    input  logic [1:0]         addr,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    input  logic               taken,
    input  logic               eret,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id
);

    intc_state_t        state_q, state_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] req_q;
    logic [ID_W-1:0]    id_q, id_d;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    win_id;
    logic               win_any;
    logic [ID_W-1:0]    enc_start;
    logic               accept;
    logic               unused_wr;

    assign unused_wr = ^wr_data;
    assign eligible  = pend_q & mask_q;
    assign accept    = (state_q == ASSERT) && taken;

    intc_prio_enc #(
        .NUM_SRC(NUM_SRC),
        .ID_W   (ID_W)
    ) u_prio_enc (
        .in    (eligible),
        .start (enc_start),
        .out_id(win_id),
        .any   (win_any)
    );

`ifdef ROUND_ROBIN_EN
    logic [ID_W-1:0] last_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= ID_W'(NUM_SRC - 1);
        end else if (accept) begin
            last_q <= id_q;
        end
    end

    assign enc_start = (last_q == ID_W'(NUM_SRC - 1)) ? '0 : last_q + 1'b1;
`else
    assign enc_start = '0;
`endif

    always_comb begin
        clr = '0;
        if (wr_en && addr == INTC_PEND) begin
            clr = wr_data[NUM_SRC-1:0];
        end
        if (accept) begin
            clr = clr | (NUM_SRC'(1) << id_q);
        end
        // New edges are applied after the clear so a same-cycle set survives.
        pend_d = (pend_q & ~clr) | (req & ~req_q);
        mask_d = (wr_en && addr == INTC_MASK) ? wr_data[NUM_SRC-1:0] : mask_q;
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    id_d    = win_id;
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (taken) begin
                    state_d = SERVICE;
                end else if (!eligible[id_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eret) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            pend_q  <= '0;
            req_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            req_q   <= req;
            id_q    <= id_d;
        end
    end

    assign irq    = (state_q == ASSERT);
    assign irq_id = id_q;

    always_comb begin
        rd_data = '0;
        unique case (addr)
            INTC_MASK:   rd_data[NUM_SRC-1:0] = mask_q;
            INTC_PEND:   rd_data[NUM_SRC-1:0] = pend_q;
            INTC_ACTIVE: begin
                rd_data[31]       = (state_q == SERVICE);
                rd_data[ID_W-1:0] = id_q;
            end
            default:     rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter: directed scenarios then randomized traffic
// against a cycle-level reference model.
module tb_interrupt_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  req = 8'h00;
    logic        wr_en = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wr_data = 32'h0;
    logic [31:0] rd_data;
    logic        taken = 1'b0;
    logic        eret = 1'b0;
    logic        irq;
    logic [2:0]  irq_id;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = nothing offered, 1 = offered to cp0, 2 = in handler.
    logic [7:0] m_mask, m_pend, m_reqq;
    int         m_phase;
    logic [2:0] m_id;
`ifdef ROUND_ROBIN_EN
    logic [2:0] m_last;
`endif

    always #5 clock = ~clock;

    interrupt_arbiter #(
        .NUM_SRC(8),
        .ID_W   (3)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .wr_en  (wr_en),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .taken  (taken),
        .eret   (eret),
        .irq    (irq),
        .irq_id (irq_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
            $error("%s differs", tag);
        end
    endtask

    task automatic model_reset();
        m_mask  = 8'h00;
        m_pend  = 8'h00;
        m_reqq  = 8'h00;
        m_phase = 0;
        m_id    = 3'd0;
`ifdef ROUND_ROBIN_EN
        m_last  = 3'd7;
`endif
    endtask

    function automatic logic [2:0] pick(input logic [7:0] elig);
        int unsigned start;
        int unsigned idx;
`ifdef ROUND_ROBIN_EN
        start = (32'(m_last) + 1) % 8;
`else
        start = 0;
`endif
        for (int k = 0; k < 8; k++) begin
            idx = (start + 32'(k)) % 8;
            if (elig[idx[2:0]]) return idx[2:0];
        end
        return 3'd0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {24'h0, m_mask};
            2'd1:    return {24'h0, m_pend};
            2'd2:    return {(m_phase == 2), 28'h0, m_id};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [7:0] elig, clr;
        elig = m_pend & m_mask;
        clr  = 8'h00;
        if (wr_en && addr == 2'd1) clr = wr_data[7:0];
        if (m_phase == 1 && taken) clr[m_id] = 1'b1;
        m_pend = (m_pend & ~clr) | (req & ~m_reqq);
        if (wr_en && addr == 2'd0) m_mask = wr_data[7:0];
        m_reqq = req;
        case (m_phase)
            0: if (elig != 8'h00) begin
                m_id    = pick(elig);
                m_phase = 1;
            end
            1: if (taken) begin
                m_phase = 2;
`ifdef ROUND_ROBIN_EN
                m_last  = m_id;
`endif
            end else if (!elig[m_id]) begin
                m_phase = 0;
            end
            2: if (eret) m_phase = 0;
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_model();
        check("model_irq", {31'h0, irq}, {31'h0, (m_phase == 1)});
        if (m_phase != 0) check("model_irq_id", {29'h0, irq_id}, {29'h0, m_id});
        check("model_rd_data", rd_data, model_read(addr));
    endtask

    // One clock: inputs already driven at the falling edge; pulses last one cycle.
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check_model();
        @(negedge clock);
        wr_en = 1'b0;
        taken = 1'b0;
        eret  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        tick();
    endtask

    task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic serve_single(input int src);
        req = 8'h00;
        req[src] = 1'b1;
        tick();
        req = 8'h00;
        tick();
        taken = 1'b1;
        tick();
        eret = 1'b1;
        tick();
    endtask

    logic [2:0] first_id, second_id;

    initial begin
        model_reset();
        #1;
        check("reset_irq", {31'h0, irq}, 32'h0);
        check("reset_irq_id", {29'h0, irq_id}, 32'h0);
        read_chk("reset_mask", 2'd0, 32'h0);
        read_chk("reset_pend", 2'd1, 32'h0);
        read_chk("reset_active", 2'd2, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Single source end to end.
        wr(2'd0, 32'hFF);
        read_chk("t2_mask", 2'd0, 32'hFF);
        req = 8'h20;
        tick();
        read_chk("t2_pend", 2'd1, 32'h20);
        check("t2_irq_before", {31'h0, irq}, 32'h0);
        tick();
        check("t2_irq", {31'h0, irq}, 32'h1);
        check("t2_irq_id", {29'h0, irq_id}, 32'h5);
        req = 8'h00;
        taken = 1'b1;
        tick();
        read_chk("t2_pend_taken", 2'd1, 32'h0);
        read_chk("t2_active", 2'd2, 32'h8000_0005);
        eret = 1'b1;
        tick();
        check("t2_irq_eret", {31'h0, irq}, 32'h0);
        read_chk("t2_active_idle", 2'd2, 32'h0000_0005);

        // Masked source becomes eligible once unmasked.
        wr(2'd0, 32'h0F);
        req = 8'h40;
        tick();
        read_chk("t3_pend", 2'd1, 32'h40);
        tick();
        check("t3_irq_masked", {31'h0, irq}, 32'h0);
        wr(2'd0, 32'hFF);
        tick();
        check("t3_irq", {31'h0, irq}, 32'h1);
        check("t3_irq_id", {29'h0, irq_id}, 32'h6);
        req = 8'h00;
        taken = 1'b1;
        tick();
        eret = 1'b1;
        tick();

        // Two simultaneous requests.
        serve_single(1);
`ifdef ROUND_ROBIN_EN
        first_id  = 3'd4;
        second_id = 3'd1;
`else
        first_id  = 3'd1;
        second_id = 3'd4;
`endif
        req = 8'h12;
        tick();
        read_chk("t4_pend", 2'd1, 32'h12);
        req = 8'h00;
        tick();
        check("t4_first", {29'h0, irq_id}, {29'h0, first_id});
        taken = 1'b1;
        tick();
        read_chk("t4_active_first", 2'd2, {1'b1, 28'h0, first_id});
        eret = 1'b1;
        tick();
        tick();
        check("t4_second_irq", {31'h0, irq}, 32'h1);
        check("t4_second", {29'h0, irq_id}, {29'h0, second_id});
        taken = 1'b1;
        tick();
        eret = 1'b1;
        tick();

        // Winner cleared by software while offered.
        req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        check("t5_irq", {31'h0, irq}, 32'h1);
        check("t5_irq_id", {29'h0, irq_id}, 32'h3);
        wr(2'd1, 32'h08);
        tick();
        check("t5_irq_dropped", {31'h0, irq}, 32'h0);
        read_chk("t5_pend", 2'd1, 32'h0);
        read_chk("t5_active", 2'd2, 32'h0000_0003);

        // Level held high sets pending once; set beats taken-clear.
        req = 8'h04;
        tick();
        tick();
        check("t6_irq_id", {29'h0, irq_id}, 32'h2);
        taken = 1'b1;
        tick();
        eret = 1'b1;
        tick();
        tick();
        read_chk("t6_pend_once", 2'd1, 32'h0);
        req = 8'h05;
        tick();
        req = 8'h04;
        tick();
        check("t6_second_handler", {29'h0, irq_id}, 32'h0);
        taken = 1'b1;
        tick();
        eret = 1'b1;
        tick();
        read_chk("t6_pend_still_held", 2'd1, 32'h0);
        req = 8'h00;
        tick();
        req = 8'h04;
        tick();
        tick();
        check("t6_offer2", {29'h0, irq_id}, 32'h2);
        req = 8'h00;
        tick();
        req = 8'h04;
        taken = 1'b1;
        tick();
        read_chk("t6_set_wins", 2'd1, 32'h04);
        read_chk("t6_active", 2'd2, 32'h8000_0002);
        req = 8'h00;
        eret = 1'b1;
        wr(2'd1, 32'h04);

        // Asynchronous reset in the middle of a handler.
        req = 8'h80;
        tick();
        req = 8'h00;
        tick();
        taken = 1'b1;
        tick();
        read_chk("t1_in_service", 2'd2, 32'h8000_0007);
        reset = 1'b0;
        #1;
        check("t1_irq", {31'h0, irq}, 32'h0);
        check("t1_irq_id", {29'h0, irq_id}, 32'h0);
        read_chk("t1_mask", 2'd0, 32'h0);
        read_chk("t1_pend", 2'd1, 32'h0);
        read_chk("t1_active", 2'd2, 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            req     = req ^ 8'($urandom & $urandom & $urandom);
            wr_en   = ($urandom_range(0, 5) == 0);
            addr    = 2'($urandom_range(0, 3));
            wr_data = $urandom;
            if (wr_en && addr == 2'd0 && $urandom_range(0, 1) == 0) wr_data[7:0] = 8'hFF;
            taken   = ($urandom_range(0, 2) == 0);
            eret    = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
